regfile_dump_reader: RTL

//   Debug/observation engine that reads a contiguous range of the 32x32 MIPS

---
 rtl/regfile_dump_reader.sv | 113 +++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// Register-file dump engine. It borrows one asynchronous regfile read port
// and streams a contiguous, wrapping range of registers out over a
// valid/ready interface. Each word is tagged with its register number.
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W:0]   Count,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  output logic [DATA_W-1:0] OutData,
  output logic [ADDR_W-1:0] OutAddr,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;

  // Datapath strobes decoded from the FSM.
  logic load;     // latch a new request
  logic capture;  // move RdData into the output register and advance
  logic drop;     // final word accepted, retire OutValid

  // State register. Reset aborts any dump in flight without a Done pulse.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and datapath strobe decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          if (Count != '0) begin
            load      = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_FETCH: begin
        capture   = 1'b1;
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        // Capture the next word on the same edge as the handshake, which keeps
        // OutValid high and gives one word per cycle.
        if (out_valid && OutReady) begin
          if (remaining != '0) begin
            capture = 1'b1;
          end else begin
            drop      = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pointer, word counter and output holding register. The output register
  // only changes on a capture, so it stays stable while the sink stalls.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ptr       <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      ptr       <= StartAddr;
      remaining <= Count;
    end else if (capture) begin
      // RdData is combinational from the regfile. A write to the same
      // register on this edge is therefore seen as its pre-write value.
      out_data  <= RdData;
      out_addr  <= ptr;
      out_valid <= 1'b1;
      ptr       <= ptr + ADDR_W'(1);  // wraps modulo the regfile depth
      remaining <= remaining - (ADDR_W+1)'(1);
    end else if (drop) begin
      out_valid <= 1'b0;
    end
  end

  assign RdAddr   = ptr;
  assign OutData  = out_data;
  assign OutAddr  = out_addr;
  assign OutValid = out_valid;
  assign Busy     = (state != S_IDLE);
  assign Done     = (state == S_DONE);

endmodule
